// File: rtl/hv_sram_responder_if.sv
// Request/response handshake and table-load bus of the hypervector SRAM responder.
interface hv_sram_responder_if #(
  parameter int HV_DIMENSION = 2000,
  parameter int ADDR_WIDTH   = 5
);
  logic                    ReqValid_SI;
  logic                    ReqReady_SO;
  logic [ADDR_WIDTH-1:0]   Addr_DI;
  logic                    RspValid_SO;
  logic                    RspReady_SI;
  logic [0:HV_DIMENSION-1] IMOut_DO;
  logic [0:HV_DIMENSION-1] ProjNeg_DO;
  logic [0:HV_DIMENSION-1] ProjPos_DO;
  logic                    AddrErr_SO;
  logic                    WrEn_SI;
  logic [1:0]              WrSel_DI;
  logic [ADDR_WIDTH-1:0]   WrAddr_DI;
  logic [0:HV_DIMENSION-1] WrData_DI;

  modport slave (
    input  ReqValid_SI, Addr_DI, RspReady_SI, WrEn_SI, WrSel_DI, WrAddr_DI, WrData_DI,
    output ReqReady_SO, RspValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO, AddrErr_SO
  );
  modport master (
    output ReqValid_SI, Addr_DI, RspReady_SI, WrEn_SI, WrSel_DI, WrAddr_DI, WrData_DI,
    input  ReqReady_SO, RspValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO, AddrErr_SO
  );
endinterface

// File: rtl/hv_sram_responder.sv
// Three-table hypervector row store (IM, ProjNeg, ProjPos) answering one request
// at a time after a fixed read latency, with a valid/ready response handshake.
module hv_sram_responder #(
  parameter int HV_DIMENSION   = 2000,
  parameter int INPUT_CHANNELS = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int READ_LATENCY   = 2
) (
  input  logic               Clk_CI,
  input  logic               Reset_RI,
  hv_sram_responder_if.slave bus
);
  typedef logic [0:HV_DIMENSION-1] row_t;
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] NUM_ROWS = (ADDR_WIDTH+1)'(INPUT_CHANNELS);
  localparam logic [3:0]          LAT_M1   = 4'(READ_LATENCY - 1);

  row_t   im_mem  [INPUT_CHANNELS];
  row_t   neg_mem [INPUT_CHANNELS];
  row_t   pos_mem [INPUT_CHANNELS];
  state_t state;
  logic [3:0] cnt;
  logic   rd_ok, wr_ok;
  row_t   rd_im, rd_neg, rd_pos;

  assign rd_ok  = {1'b0, bus.Addr_DI} < NUM_ROWS;
  assign wr_ok  = bus.WrEn_SI && (bus.WrSel_DI != 2'd3) && ({1'b0, bus.WrAddr_DI} < NUM_ROWS);
  assign rd_im  = rd_ok ? im_mem[bus.Addr_DI]  : '0;
  assign rd_neg = rd_ok ? neg_mem[bus.Addr_DI] : '0;
  assign rd_pos = rd_ok ? pos_mem[bus.Addr_DI] : '0;

  // Tables are never cleared; reset only blocks the write on that edge.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RI && wr_ok) begin
      case (bus.WrSel_DI)
        2'd0:    im_mem[bus.WrAddr_DI]  <= bus.WrData_DI;
        2'd1:    neg_mem[bus.WrAddr_DI] <= bus.WrData_DI;
        2'd2:    pos_mem[bus.WrAddr_DI] <= bus.WrData_DI;
        default: ;
      endcase
    end
  end

  // Rows are captured on the accept edge, so a same-edge write sees the old row.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.ReqReady_SO <= 1'b1;
      bus.RspValid_SO <= 1'b0;
      bus.AddrErr_SO  <= 1'b0;
      bus.IMOut_DO    <= '0;
      bus.ProjNeg_DO  <= '0;
      bus.ProjPos_DO  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.ReqValid_SI) begin
          bus.IMOut_DO    <= rd_im;
          bus.ProjNeg_DO  <= rd_neg;
          bus.ProjPos_DO  <= rd_pos;
          bus.AddrErr_SO  <= !rd_ok;
          bus.ReqReady_SO <= 1'b0;
          if (READ_LATENCY == 1) begin
            state           <= RESP;
            bus.RspValid_SO <= 1'b1;
          end else begin
            state <= READ;
            cnt   <= LAT_M1;
          end
        end
        READ: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state           <= RESP;
            bus.RspValid_SO <= 1'b1;
          end
        end
        RESP: if (bus.RspReady_SI) begin
          state           <= IDLE;
          bus.RspValid_SO <= 1'b0;
          bus.ReqReady_SO <= 1'b1;
        end
        default: begin
          state           <= IDLE;
          bus.RspValid_SO <= 1'b0;
          bus.ReqReady_SO <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hv_sram_responder.sv
// Scoreboard bench: driver pushes expected rows from a table model, negedge monitor compares.
module tb_hv_sram_responder;
  localparam int HV = 64, CH = 20, AW = 5, LAT = 2;
  typedef logic [0:HV-1] row_t;
  typedef struct { row_t im; row_t neg; row_t pos; logic err; int acc; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  hv_sram_responder_if #(.HV_DIMENSION(HV), .ADDR_WIDTH(AW)) bus ();
  hv_sram_responder_if #(.HV_DIMENSION(HV), .ADDR_WIDTH(AW)) bus1 ();

  hv_sram_responder #(.HV_DIMENSION(HV), .INPUT_CHANNELS(CH), .ADDR_WIDTH(AW), .READ_LATENCY(LAT))
    dut (.Clk_CI(clk), .Reset_RI(rst), .bus(bus.slave));
  hv_sram_responder #(.HV_DIMENSION(HV), .INPUT_CHANNELS(CH), .ADDR_WIDTH(AW), .READ_LATENCY(1))
    dut1 (.Clk_CI(clk), .Reset_RI(rst1), .bus(bus1.slave));

  exp_t sbq[$];
  row_t m_im [CH];
  row_t m_neg[CH];
  row_t m_pos[CH];
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic row_t rnd_row();
    return {$urandom(), $urandom()};
  endfunction

  // One cycle of stimulus; the model reads before it writes, as the table must.
  task automatic drive(input logic rv, input logic [AW-1:0] a, input logic rr,
                       input logic we, input logic [1:0] ws, input logic [AW-1:0] wa, input row_t wd);
    exp_t e;
    @(posedge clk); #1;
    bus.ReqValid_SI = rv; bus.Addr_DI = a; bus.RspReady_SI = rr;
    bus.WrEn_SI = we; bus.WrSel_DI = ws; bus.WrAddr_DI = wa; bus.WrData_DI = wd;
    if (rv && bus.ReqReady_SO && !rst) begin
      e.err = (a >= CH);
      e.im  = e.err ? '0 : m_im[a];
      e.neg = e.err ? '0 : m_neg[a];
      e.pos = e.err ? '0 : m_pos[a];
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    if (we && ws < 3 && wa < CH && !rst) begin
      if (ws == 0) m_im[wa] = wd;
      else if (ws == 1) m_neg[wa] = wd;
      else m_pos[wa] = wd;
    end
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, '0, rr, 1'b0, 2'd3, '0, '0);
  endtask

  // Monitor
  exp_t m_e;
  logic seen = 1'b0;
  row_t last_im = '0, last_neg = '0, last_pos = '0;
  logic last_err = 1'b0;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst) begin
        chk("rst_ready", 64'(bus.ReqReady_SO), 64'd1);
        chk("rst_valid", 64'(bus.RspValid_SO), 64'd0);
        chk("rst_err", 64'(bus.AddrErr_SO), 64'd0);
        chk("rst_im", bus.IMOut_DO, '0);
        chk("rst_neg", bus.ProjNeg_DO, '0);
        chk("rst_pos", bus.ProjPos_DO, '0);
        seen = 1'b0;
        last_im = '0; last_neg = '0; last_pos = '0; last_err = 1'b0;
      end else if (bus.RspValid_SO) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 64'(bus.RspValid_SO), 64'd0);
        end else begin
          m_e = sbq[0];
          chk("ready_low_in_resp", 64'(bus.ReqReady_SO), 64'd0);
          chk("rsp_im", bus.IMOut_DO, m_e.im);
          chk("rsp_neg", bus.ProjNeg_DO, m_e.neg);
          chk("rsp_pos", bus.ProjPos_DO, m_e.pos);
          chk("rsp_err", 64'(bus.AddrErr_SO), 64'(m_e.err));
          if (!seen) begin
            chk("latency", 64'(cyc - m_e.acc), 64'(LAT - 1));
            seen = 1'b1;
          end
          if (bus.RspReady_SI) begin
            last_im = m_e.im; last_neg = m_e.neg; last_pos = m_e.pos; last_err = m_e.err;
            void'(sbq.pop_front());
            seen = 1'b0;
          end
        end
      end else if (sbq.size() != 0 && cyc >= sbq[0].acc) begin
        m_e = sbq[0];
        chk("ready_low_in_read", 64'(bus.ReqReady_SO), 64'd0);
        chk("read_im", bus.IMOut_DO, m_e.im);
        chk("read_err", 64'(bus.AddrErr_SO), 64'(m_e.err));
      end else begin
        chk("idle_ready", 64'(bus.ReqReady_SO), 64'd1);
        chk("hold_im", bus.IMOut_DO, last_im);
        chk("hold_neg", bus.ProjNeg_DO, last_neg);
        chk("hold_pos", bus.ProjPos_DO, last_pos);
        chk("hold_err", 64'(bus.AddrErr_SO), 64'(last_err));
      end
    end
  end

  row_t r1, r2, r3, old3;
  int nrsp;

  initial begin
    bus.ReqValid_SI = 0; bus.Addr_DI = '0; bus.RspReady_SI = 0;
    bus.WrEn_SI = 0; bus.WrSel_DI = 2'd3; bus.WrAddr_DI = '0; bus.WrData_DI = '0;
    bus1.ReqValid_SI = 0; bus1.Addr_DI = '0; bus1.RspReady_SI = 0;
    bus1.WrEn_SI = 0; bus1.WrSel_DI = 2'd3; bus1.WrAddr_DI = '0; bus1.WrData_DI = '0;
    repeat (3) idle(1'b0);
    rst = 1'b0;
    for (int r = 0; r < CH; r++)
      for (int s = 0; s < 3; s++) drive(1'b0, '0, 1'b0, 1'b1, 2'(s), 5'(r), rnd_row());

    // basic read of row 3
    drive(1'b0, '0, 1'b1, 1'b1, 2'd0, 5'd3, '1);
    drive(1'b0, '0, 1'b1, 1'b1, 2'd1, 5'd3, {16{4'hA}});
    drive(1'b0, '0, 1'b1, 1'b1, 2'd2, 5'd3, {16{4'h5}});
    drive(1'b1, 5'd3, 1'b1, 1'b0, 2'd3, '0, '0);
    repeat (LAT + 1) idle(1'b1);

    // backpressure
    drive(1'b1, 5'd5, 1'b0, 1'b0, 2'd3, '0, '0);
    repeat (LAT + 5) drive(1'b1, 5'd7, 1'b0, 1'b0, 2'd3, '0, '0);
    idle(1'b1); idle(1'b1);

    // out-of-range read with an ignored out-of-range write
    drive(1'b1, 5'd31, 1'b1, 1'b1, 2'd0, 5'd25, rnd_row());
    repeat (LAT + 1) idle(1'b1);

    // collision: write row 3 on the accept edge, then read it again
    drive(1'b1, 5'd3, 1'b1, 1'b1, 2'd0, 5'd3, rnd_row());
    repeat (LAT + 1) idle(1'b1);
    drive(1'b1, 5'd3, 1'b1, 1'b0, 2'd3, '0, '0);
    repeat (LAT + 1) idle(1'b1);

    // reset one cycle after accept; write during reset is dropped
    drive(1'b1, 5'd3, 1'b1, 1'b0, 2'd3, '0, '0);
    idle(1'b1);
    rst = 1'b1; sbq.delete();
    drive(1'b0, '0, 1'b1, 1'b1, 2'd0, 5'd3, rnd_row());
    idle(1'b1);
    rst = 1'b0;
    repeat (3) idle(1'b1);
    drive(1'b1, 5'd3, 1'b1, 1'b0, 2'd3, '0, '0);
    repeat (LAT + 1) idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), rnd_row());
    for (int i = 0; i < 30 && sbq.size() != 0; i++) idle(1'b1);
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    idle(1'b1);

    // READ_LATENCY=1 instance: back-to-back requests every two cycles
    r1 = rnd_row(); r2 = rnd_row(); r3 = rnd_row();
    @(posedge clk); #1 rst1 = 1'b0;
    bus1.WrEn_SI = 1; bus1.WrAddr_DI = 5'd3; bus1.WrSel_DI = 2'd0; bus1.WrData_DI = r1;
    @(posedge clk); #1 bus1.WrSel_DI = 2'd1; bus1.WrData_DI = r2;
    @(posedge clk); #1 bus1.WrSel_DI = 2'd2; bus1.WrData_DI = r3;
    @(posedge clk); #1 bus1.WrEn_SI = 0;
    bus1.ReqValid_SI = 1; bus1.Addr_DI = 5'd3; bus1.RspReady_SI = 1;
    nrsp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("l1_ready", 64'(bus1.ReqReady_SO), 64'(i % 2 == 0));
      chk("l1_valid", 64'(bus1.RspValid_SO), 64'(i % 2));
      if (bus1.RspValid_SO) begin
        nrsp++;
        chk("l1_im", bus1.IMOut_DO, r1);
        chk("l1_neg", bus1.ProjNeg_DO, r2);
        chk("l1_pos", bus1.ProjPos_DO, r3);
        chk("l1_err", 64'(bus1.AddrErr_SO), 64'd0);
      end
    end
    chk("l1_count", 64'(nrsp), 64'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
